addr_narrow_pipe: RTL and testbench

ADDR_NARROW_PIPE -- requirements
Module: addr_narrow_pipe

---
 rtl/addr_narrow_pipe_pkg.sv | 26 ++
 rtl/addr_narrow_pipe_if.sv | 29 ++
 rtl/addr_narrow_pipe_sat_counter.sv | 36 +++
 rtl/addr_narrow_pipe.sv | 105 ++++++++++
 tb/tb_addr_narrow_pipe.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/addr_narrow_pipe_pkg.sv
// Shared definitions for the address-narrowing pipeline: mode encodings,
// default datapath widths and the raw-mode decoder.
package addr_narrow_pipe_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 18;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    MODE_TRUNC = 2'b00,
    MODE_SAT   = 2'b01,
    MODE_FDROP = 2'b10
  } mode_e;

  // The unused encoding 2'b11 is folded onto truncate.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'b01:   m = MODE_SAT;
      2'b10:   m = MODE_FDROP;
      default: m = MODE_TRUNC;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/addr_narrow_pipe_if.sv
// Producer/consumer bus of the address-narrowing pipeline. The slave modport
// is the pipeline's view; the master modport is the surrounding logic's view.
interface addr_narrow_pipe_if
  import addr_narrow_pipe_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) ();

  logic [1:0]       mode;
  logic             in_valid;
  logic [IN_W-1:0]  in_addr;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_addr;
  logic             out_oor;
  logic             out_ready;

  modport slave (
    input  mode, in_valid, in_addr, out_ready,
    output in_ready, out_valid, out_addr, out_oor
  );

  modport master (
    output mode, in_valid, in_addr, out_ready,
    input  in_ready, out_valid, out_addr, out_oor
  );

endinterface

// File: rtl/addr_narrow_pipe_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear that coincides with
// an increment leaves the counter at one, so the coinciding event is counted.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear has priority but still honours a same-cycle increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/addr_narrow_pipe.sv
// Single-entry pipeline that narrows a wide address to OUT_W bits using one of
// three modes (truncate, saturate, fault-drop) and tracks out-of-range words.
// OUT_W must lie in 1..IN_W-1 so that an out-of-range field exists.
module addr_narrow_pipe
  import addr_narrow_pipe_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  addr_narrow_pipe_if.slave   bus,
  input  logic                clr_err,
  output logic                err_sticky,
  output logic [CNT_W-1:0]    err_count
);

  logic [IN_W-1:0]  in_addr_w;
  mode_e            mode_w;
  logic             oor;
  logic             in_ready;
  logic             in_xfer;
  logic             out_xfer;
  logic             drop;
  logic             load;
  logic             err_inc;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_addr_q,  out_addr_d;
  logic             out_oor_q,   out_oor_d;
  logic             err_sticky_q, err_sticky_d;

  assign in_addr_w = bus.in_addr;
  assign mode_w    = decode_mode(bus.mode);
  assign oor       = |in_addr_w[IN_W-1:OUT_W];

  // The slot can take a new word when empty or when the held word leaves now.
  assign in_ready  = !out_valid_q || bus.out_ready;
  assign in_xfer   = bus.in_valid && in_ready;
  assign out_xfer  = out_valid_q && bus.out_ready;

  // Fault-drop consumes an out-of-range word without loading it.
  assign drop      = in_xfer && oor && (mode_w == MODE_FDROP);
  assign load      = in_xfer && !drop;
  assign err_inc   = in_xfer && oor;

  // Output slot next state: load beats unload so back-to-back words have no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_oor_d   = out_oor_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_oor_d   = oor;
      if ((mode_w == MODE_SAT) && oor) begin
        out_addr_d = '1;
      end else begin
        out_addr_d = in_addr_w[OUT_W-1:0];
      end
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Sticky error next state; a same-cycle clear still records the new error.
  always_comb begin
    err_sticky_d = err_sticky_q | err_inc;
    if (clr_err) begin
      err_sticky_d = err_inc;
    end
  end

  // Output slot and sticky flag registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_oor_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_oor_q    <= out_oor_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (err_inc),
    .clr_i   (clr_err),
    .count_o (err_count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_oor   = out_oor_q;
  assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_addr_narrow_pipe.sv
// Directed bench for addr_narrow_pipe with a scoreboard on the output port.
module tb_addr_narrow_pipe;
  import addr_narrow_pipe_pkg::*;

  localparam int IN_W  = 32;
  localparam int OUT_W = 18;

  typedef struct packed {
    logic [OUT_W-1:0] addr;
    logic             oor;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_a, clr_b;
  logic       sticky_a, sticky_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  addr_narrow_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_a ();
  addr_narrow_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_b ();

  addr_narrow_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(8)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_a),
    .clr_err    (clr_a),
    .err_sticky (sticky_a),
    .err_count  (cnt_a)
  );

  addr_narrow_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(2)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_b),
    .clr_err    (clr_b),
    .err_sticky (sticky_b),
    .err_count  (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference narrowing; returns 1 when the word is loaded into the slot.
  function automatic logic model(input logic [1:0] m, input logic [31:0] a, output exp_t e);
    logic is_oor;
    is_oor = (a[31:18] != 14'd0);
    e.oor  = is_oor;
    e.addr = a[17:0];
    if (m == 2'b01 && is_oor) e.addr = 18'h3FFFF;
    return !(m == 2'b10 && is_oor);
  endfunction

  // Offer one word on bus_a; return one cycle after the accepting edge.
  task automatic offer(input logic [1:0] m, input logic [31:0] a, input string tag);
    exp_t e;
    bit   done;
    done = 0;
    bus_a.mode     = m;
    bus_a.in_addr  = a;
    bus_a.in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus_a.in_ready) begin
        if (model(m, a, e)) sb_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    bus_a.in_valid = 1'b0;
    if (!done) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  // Scoreboard: every output transfer on bus_a must match the oldest expected word.
  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed %0h/%0b expected no word", bus_a.out_addr, bus_a.out_oor);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        assert ({bus_a.out_addr, bus_a.out_oor} === {e.addr, e.oor}) else begin
          n_err++;
          $error("FAIL sb_word: observed %0h/%0b expected %0h/%0b",
                 bus_a.out_addr, bus_a.out_oor, e.addr, e.oor);
        end
      end
    end
  end

  logic [31:0] tp_addr [3];
  logic [1:0]  tp_mode [3];
  logic [17:0] tp_exp  [3];

  initial begin
    exp_t e;
    logic [1:0] exp_sat [5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    tp_addr = '{32'h0003_FFFF, 32'h0004_0000, 32'h0004_0000};
    tp_mode = '{2'b00, 2'b00, 2'b01};
    tp_exp  = '{18'h3FFFF, 18'h00000, 18'h3FFFF};

    bus_a.mode = 2'b00; bus_a.in_valid = 1'b0; bus_a.in_addr = '0; bus_a.out_ready = 1'b1;
    bus_b.mode = 2'b00; bus_b.in_valid = 1'b0; bus_b.in_addr = '0; bus_b.out_ready = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0;

    // Reset state, before any clock edge.
    #2;
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_out_addr",  64'(bus_a.out_addr),  64'd0);
    check("rst_in_ready",  64'(bus_a.in_ready),  64'd1);
    check("rst_err_count", 64'(cnt_a),           64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", 64'(bus_a.out_valid), 64'd0);

    // In-range word in all four modes.
    for (int m = 0; m < 4; m++) begin
      offer(2'(m), 32'h0002_1088, "inrange");
      check("inrange_valid", 64'(bus_a.out_valid), 64'd1);
      check("inrange_addr",  64'(bus_a.out_addr),  64'h21088);
      check("inrange_oor",   64'(bus_a.out_oor),   64'd0);
    end
    @(posedge clk); #1;
    check("inrange_drain", 64'(bus_a.out_valid), 64'd0);
    check("inrange_cnt",   64'(cnt_a),           64'd0);
    check("inrange_stk",   64'(sticky_a),        64'd0);

    // Out-of-range word in each mode.
    offer(2'b00, 32'hA2BD_FFFF, "oor_trunc");
    check("oor_trunc_addr", 64'(bus_a.out_addr), 64'h1FFFF);
    check("oor_trunc_oor",  64'(bus_a.out_oor),  64'd1);
    check("oor_trunc_cnt",  64'(cnt_a),          64'd1);
    check("oor_trunc_stk",  64'(sticky_a),       64'd1);
    offer(2'b01, 32'hA2BD_FFFF, "oor_sat");
    check("oor_sat_addr", 64'(bus_a.out_addr), 64'h3FFFF);
    check("oor_sat_oor",  64'(bus_a.out_oor),  64'd1);
    check("oor_sat_cnt",  64'(cnt_a),          64'd2);
    offer(2'b10, 32'hA2BD_FFFF, "oor_fdrop");
    check("oor_fdrop_valid", 64'(bus_a.out_valid), 64'd0);
    check("oor_fdrop_cnt",   64'(cnt_a),           64'd3);
    @(posedge clk); #1;
    check("oor_fdrop_valid2", 64'(bus_a.out_valid), 64'd0);
    offer(2'b11, 32'hA2BD_FFFF, "oor_m11");
    check("oor_m11_addr", 64'(bus_a.out_addr), 64'h1FFFF);
    check("oor_m11_cnt",  64'(cnt_a),          64'd4);

    // Plain clear, then clear colliding with an out-of-range word.
    @(posedge clk); #1;
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    check("clr_cnt", 64'(cnt_a),    64'd0);
    check("clr_stk", 64'(sticky_a), 64'd0);
    clr_a = 1'b1;
    offer(2'b00, 32'hFFFF_0000, "clr_coll");
    clr_a = 1'b0;
    check("clr_coll_cnt", 64'(cnt_a),    64'd1);
    check("clr_coll_stk", 64'(sticky_a), 64'd1);

    // Full throughput across the range boundary.
    for (int i = 0; i < 3; i++) begin
      bus_a.mode     = tp_mode[i];
      bus_a.in_addr  = tp_addr[i];
      bus_a.in_valid = 1'b1;
      check("tp_in_ready", 64'(bus_a.in_ready), 64'd1);
      if (model(tp_mode[i], tp_addr[i], e)) sb_q.push_back(e);
      @(posedge clk); #1;
      check("tp_valid", 64'(bus_a.out_valid), 64'd1);
      check("tp_addr",  64'(bus_a.out_addr),  64'(tp_exp[i]));
    end
    bus_a.in_valid = 1'b0;
    check("tp_cnt", 64'(cnt_a), 64'd3);
    @(posedge clk); #1;

    // Backpressure with a mode change while a word is held.
    bus_a.out_ready = 1'b0;
    bus_a.mode      = 2'b01;
    bus_a.in_addr   = 32'hA2BD_FFFF;
    bus_a.in_valid  = 1'b1;
    check("bp_in_ready0", 64'(bus_a.in_ready), 64'd1);
    if (model(2'b01, 32'hA2BD_FFFF, e)) sb_q.push_back(e);
    @(posedge clk); #1;
    bus_a.mode    = 2'b00;
    bus_a.in_addr = 32'h0000_0ABC;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid",    64'(bus_a.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus_a.in_ready),  64'd0);
      check("bp_addr",     64'(bus_a.out_addr),  64'h3FFFF);
      check("bp_oor",      64'(bus_a.out_oor),   64'd1);
      @(posedge clk); #1;
    end
    check("bp_cnt", 64'(cnt_a), 64'd4);
    bus_a.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus_a.in_ready), 64'd1);
    if (model(2'b00, 32'h0000_0ABC, e)) sb_q.push_back(e);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    check("bp_w2_valid", 64'(bus_a.out_valid), 64'd1);
    check("bp_w2_addr",  64'(bus_a.out_addr),  64'h00ABC);
    check("bp_w2_oor",   64'(bus_a.out_oor),   64'd0);
    @(posedge clk); #1;
    check("bp_drained", 64'(sb_q.size()), 64'd0);

    // Counter saturation on the narrow-counter instance.
    bus_b.in_addr  = 32'hFFFF_FFFF;
    bus_b.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("sat_cnt", 64'(cnt_b), 64'(exp_sat[i]));
    end
    bus_b.in_valid = 1'b0;
    check("sat_stk", 64'(sticky_b), 64'd1);

    // Reset while a word is held and err_count is 2.
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    offer(2'b00, 32'h0100_0001, "rst_w1");
    offer(2'b00, 32'h0100_0002, "rst_w2");
    bus_a.out_ready = 1'b0;
    check("pre_rst_cnt",   64'(cnt_a),           64'd2);
    check("pre_rst_valid", 64'(bus_a.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("arst_valid",    64'(bus_a.out_valid), 64'd0);
    check("arst_addr",     64'(bus_a.out_addr),  64'd0);
    check("arst_oor",      64'(bus_a.out_oor),   64'd0);
    check("arst_stk",      64'(sticky_a),        64'd0);
    check("arst_cnt",      64'(cnt_a),           64'd0);
    check("arst_in_ready", 64'(bus_a.in_ready),  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_a.out_ready = 1'b1;
    check("rel_valid", 64'(bus_a.out_valid), 64'd0);
    offer(2'b00, 32'h0001_2345, "post_rst");
    check("post_rst_word_valid", 64'(bus_a.out_valid), 64'd1);
    check("post_rst_word_addr",  64'(bus_a.out_addr),  64'h12345);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
